// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: state and length
// encodings, RAM width default and small datapath helpers.
package mem_ctrl_pkg;

  localparam int          RAM_AW_DEF  = 17;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic        WriteEnable = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LEN_B  = 2'b00,
    LEN_H  = 2'b01,
    LEN_W  = 2'b10,
    LEN_WX = 2'b11
  } len_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side request/response bus plus the byte-wide RAM port of mem_ctrl.
// master = pipeline stages and RAM environment, slave = the controller.
interface mem_ctrl_if #(
  parameter int RAM_AW = 17
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_cancel;
  logic              if_ready;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              stall_req;
  logic [RAM_AW-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport master (
    output if_req, if_addr, if_cancel, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    input  if_ready, if_inst, mem_ready, mem_rdata, stall_req, ram_a, ram_dout, ram_wr
  );

  modport slave (
    input  if_req, if_addr, if_cancel, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
    output if_ready, if_inst, mem_ready, mem_rdata, stall_req, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: walks byte addresses base..base+N-1, drives write data or
// collects read bytes (one cycle behind the address) into little-endian lanes.
module mem_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_we,
  input  logic [2:0]        start_n,
  input  logic [RAM_AW-1:0] start_addr,
  input  logic [31:0]       start_wdata,
  input  logic              abort,
  input  logic [7:0]        ram_din,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  output logic              last_issue,
  output logic              last_cap,
  output logic [31:0]       rdata
);

  logic [RAM_AW-1:0] base_r;
  logic [2:0]        n_r;
  logic              we_r;
  logic [31:0]       wdata_r;
  logic [1:0]        iss_idx_r;
  logic              iss_vld_r;
  logic [1:0]        cap_idx_r;
  logic              cap_vld_r;
  logic [31:0]       lanes_r;
  logic [RAM_AW-1:0] ram_a_r;
  logic [7:0]        ram_dout_r;
  logic              ram_wr_r;
  logic [1:0]        nxt_idx_s;

  assign nxt_idx_s  = iss_idx_r + 2'd1;
  assign last_issue = iss_vld_r & ({1'b0, iss_idx_r} == (n_r - 3'd1));
  assign last_cap   = cap_vld_r & ({1'b0, cap_idx_r} == (n_r - 3'd1));
  assign ram_a      = ram_a_r;
  assign ram_dout   = ram_dout_r;
  assign ram_wr     = ram_wr_r;

  // Merge the byte arriving this cycle so the owner can latch a complete result
  always_comb begin
    rdata = lanes_r;
    if (cap_vld_r) begin
      rdata[{cap_idx_r, 3'b000} +: 8] = ram_din;
    end else begin
      rdata = lanes_r;
    end
  end

  // Address issue, write-data drive and read-lane capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r     <= '0;
      n_r        <= 3'd0;
      we_r       <= 1'b0;
      wdata_r    <= ZERO_WORD;
      iss_idx_r  <= 2'd0;
      iss_vld_r  <= 1'b0;
      cap_idx_r  <= 2'd0;
      cap_vld_r  <= 1'b0;
      lanes_r    <= ZERO_WORD;
      ram_a_r    <= '0;
      ram_dout_r <= 8'h00;
      ram_wr_r   <= 1'b0;
    end else if (start) begin
      base_r     <= start_addr;
      n_r        <= start_n;
      we_r       <= start_we;
      wdata_r    <= start_wdata;
      iss_idx_r  <= 2'd0;
      iss_vld_r  <= 1'b1;
      cap_idx_r  <= 2'd0;
      cap_vld_r  <= 1'b0;
      lanes_r    <= ZERO_WORD;
      ram_a_r    <= start_addr;
      ram_wr_r   <= start_we;
      ram_dout_r <= start_we ? start_wdata[7:0] : 8'h00;
    end else if (abort) begin
      iss_vld_r  <= 1'b0;
      cap_vld_r  <= 1'b0;
      lanes_r    <= ZERO_WORD;
      ram_a_r    <= '0;
      ram_dout_r <= 8'h00;
      ram_wr_r   <= 1'b0;
    end else begin
      cap_vld_r <= iss_vld_r & ~we_r;
      if (cap_vld_r) begin
        lanes_r[{cap_idx_r, 3'b000} +: 8] <= ram_din;
        cap_idx_r <= cap_idx_r + 2'd1;
      end
      if (iss_vld_r) begin
        if (last_issue) begin
          iss_vld_r  <= 1'b0;
          ram_a_r    <= '0;
          ram_dout_r <= 8'h00;
          ram_wr_r   <= 1'b0;
        end else begin
          iss_idx_r  <= nxt_idx_s;
          ram_a_r    <= base_r + {{(RAM_AW-2){1'b0}}, nxt_idx_s};
          ram_wr_r   <= we_r;
          ram_dout_r <= we_r ? byte_sel(wdata_r, nxt_idx_s) : 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbiter and transaction FSM sharing one byte-wide RAM port between
// instruction fetch and the MEM stage; MEM has fixed priority.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  state_t            state_r;
  owner_t            owner_r;
  logic              if_ready_r;
  logic [31:0]       if_inst_r;
  logic              mem_ready_r;
  logic [31:0]       mem_rdata_r;
  logic              stall_r;

  logic              grant_mem_s;
  logic              grant_if_s;
  logic              start_s;
  logic              start_we_s;
  logic [2:0]        start_n_s;
  logic [RAM_AW-1:0] start_addr_s;
  logic [31:0]       start_wdata_s;
  logic              abort_s;
  logic              last_issue_s;
  logic              last_cap_s;
  logic [31:0]       seq_rdata_s;
  logic [RAM_AW-1:0] seq_ram_a_s;
  logic [7:0]        seq_ram_dout_s;
  logic              seq_ram_wr_s;
  logic              unused_addr_s;

  // Upper address bits fall outside the RAM and are deliberately dropped
  assign unused_addr_s = ^{bus.if_addr[31:RAM_AW], bus.mem_addr[31:RAM_AW]};

  // Grant selection and the request fields captured on a grant
  always_comb begin
    grant_mem_s   = 1'b0;
    grant_if_s    = 1'b0;
    start_n_s     = 3'd4;
    start_addr_s  = bus.if_addr[RAM_AW-1:0];
    start_wdata_s = ZERO_WORD;
    if (state_r == IDLE) begin
      grant_mem_s = bus.mem_req;
      grant_if_s  = ~bus.mem_req & bus.if_req & ~bus.if_cancel;
    end else begin
      grant_mem_s = 1'b0;
      grant_if_s  = 1'b0;
    end
    if (grant_mem_s) begin
      start_n_s     = len_to_n(bus.mem_len);
      start_addr_s  = bus.mem_addr[RAM_AW-1:0];
      start_wdata_s = bus.mem_wdata;
    end else begin
      start_n_s     = 3'd4;
      start_addr_s  = bus.if_addr[RAM_AW-1:0];
      start_wdata_s = ZERO_WORD;
    end
    start_s    = grant_mem_s | grant_if_s;
    start_we_s = grant_mem_s & (bus.mem_we == WriteEnable);
    abort_s    = (state_r == READ) && (owner_r == OWN_IF) && bus.if_cancel;
  end

  mem_byte_seq #(.RAM_AW(RAM_AW)) u_seq (
    .clk         (clk),
    .rst         (rst),
    .start       (start_s),
    .start_we    (start_we_s),
    .start_n     (start_n_s),
    .start_addr  (start_addr_s),
    .start_wdata (start_wdata_s),
    .abort       (abort_s),
    .ram_din     (bus.ram_din),
    .ram_a       (seq_ram_a_s),
    .ram_dout    (seq_ram_dout_s),
    .ram_wr      (seq_ram_wr_s),
    .last_issue  (last_issue_s),
    .last_cap    (last_cap_s),
    .rdata       (seq_rdata_s)
  );

  // Transaction FSM; stall_req is registered, so on leaving DONE it only
  // reflects the other requester (the owner drops its request at that edge)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      owner_r     <= OWN_IF;
      if_ready_r  <= 1'b0;
      if_inst_r   <= ZERO_WORD;
      mem_ready_r <= 1'b0;
      mem_rdata_r <= ZERO_WORD;
      stall_r     <= 1'b0;
    end else begin
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= start_we_s ? WRITE : READ;
            owner_r <= grant_mem_s ? OWN_MEM : OWN_IF;
            stall_r <= 1'b1;
          end else begin
            stall_r <= bus.if_req | bus.mem_req;
          end
        end
        READ: begin
          if (abort_s) begin
            state_r <= IDLE;
            stall_r <= bus.mem_req | (bus.if_req & ~bus.if_cancel);
          end else if (last_cap_s) begin
            state_r <= DONE;
            stall_r <= 1'b0;
            if (owner_r == OWN_IF) begin
              if_ready_r <= 1'b1;
              if_inst_r  <= seq_rdata_s;
            end else begin
              mem_ready_r <= 1'b1;
              mem_rdata_r <= seq_rdata_s;
            end
          end else begin
            stall_r <= 1'b1;
          end
        end
        WRITE: begin
          if (last_issue_s) begin
            state_r     <= DONE;
            stall_r     <= 1'b0;
            mem_ready_r <= 1'b1;
            mem_rdata_r <= ZERO_WORD;
          end else begin
            stall_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          stall_r <= (owner_r == OWN_IF) ? bus.mem_req : bus.if_req;
        end
        default: begin
          state_r <= IDLE;
          stall_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_ready  = if_ready_r;
  assign bus.if_inst   = if_inst_r;
  assign bus.mem_ready = mem_ready_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.stall_req = stall_r;
  assign bus.ram_a     = seq_ram_a_s;
  assign bus.ram_dout  = seq_ram_dout_s;
  assign bus.ram_wr    = seq_ram_wr_s;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller and arbiter that shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage (loads/stores whose address comes from EX). Each granted request becomes a serial sequence of 1, 2 or 4 byte accesses. The assembled little-endian result is returned with a one-cycle ready pulse. The block sits between the IF/MEM pipeline stages and the RAM, and drives the pipeline stall request.

## Interface
Parameters:
- RAM_AW, 17, RAM byte-address width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- if_req  in  1  IF requests a 4-byte instruction read; held until if_ready.
- if_addr  in  32  IF byte address.
- if_cancel  in  1  abandon any pending or in-flight IF transaction (branch taken).
- if_ready  out  1  one-cycle pulse; if_inst valid.
- if_inst  out  32  fetched instruction.
- mem_req  in  1  MEM requests an access; held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_len  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr  in  32  byte address (EX result).
- mem_wdata  in  32  store data; low bytes used.
- mem_ready  out  1  one-cycle pulse; load data valid / store complete.
- mem_rdata  out  32  zero-extended load data; sign extension is done in MEM.
- stall_req  out  1  high while any request is pending or in service and not yet acknowledged.
- ram_a  out  RAM_AW  RAM byte address.
- ram_dout  out  8  RAM write data.
- ram_wr  out  1  RAM write enable.
- ram_din  in  8  RAM read data; valid one cycle after ram_a is presented.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- Arbitration happens in IDLE at each clock edge:
  - mem_req wins over if_req (fixed priority).
  - A grant latches the address, length, we, wdata and owner (IF or MEM).
  - No preemption once a transaction has started.
- Byte count N: 1, 2 or 4 from mem_len; always 4 for IF.
- Byte k goes to address (addr[RAM_AW-1:0] + k) mod 2^RAM_AW. The address wraps silently; the upper address bits are ignored.
- READ:
  - Presents addresses k = 0..N-1 on consecutive cycles.
  - Captures ram_din one cycle later into byte lane k.
  - Unused lanes are 0.
  - After the last capture, goes to DONE.
- WRITE:
  - Drives ram_a = base + k, ram_dout = wdata[8k+7:8k] and ram_wr = 1 for k = 0..N-1.
  - Then goes to DONE.
- DONE:
  - Pulses the owner's ready for exactly one cycle, with the data on if_inst or mem_rdata.
  - Returns to IDLE. Requests are not sampled in DONE.
  - The requester must drop req at the edge where it sees ready, otherwise the request is re-served.
- if_cancel:
  - In IDLE: an IF request is not granted that cycle.
  - During an IF READ: the transaction is abandoned and the FSM goes to IDLE at the next edge; no if_ready is produced.
  - Ignored during MEM transactions.
- ram_wr is 1 only in WRITE. Outside WRITE, ram_dout = 0.
- ram_a = 0 in IDLE and DONE.
- stall_req = (if_req | mem_req | state != IDLE) and not in DONE.
- Reset (asynchronous, any time, including mid-transaction):
  - State → IDLE.
  - All outputs 0.
  - No partial write continues.
  - Latched data is cleared.

## Timing
- Request sampled at edge E0 (cycle 0).
- Read:
  - ram_a for byte k is presented in cycle 1+k.
  - Byte k is captured at the end of cycle 2+k.
  - Ready is high in cycle N+2.
  - Word read: ready in cycle 6. Byte read: ready in cycle 3.
- Write:
  - ram_wr is high in cycles 1..N.
  - Ready is high in cycle N+1. Word store: cycle 5.
- Back-to-back throughput: the next grant occurs at the edge ending the cycle after DONE.
- With simultaneous if_req and mem_req, MEM is served first. IF is granted in the first IDLE cycle after MEM's DONE.
- All outputs are registered.

## Structure
- Shared config package/header holds:
  - State encodings.
  - mem_len encodings (LEN_B/LEN_H/LEN_W).
  - RAM_AW default.
  - The existing ZERO_WORD / WriteEnable constants.
- Optional sub-module mem_byte_seq: byte counter, address generator and lane assembly, instantiated once. Arbitration and the FSM stay in mem_ctrl.

## Test plan
- Word fetch: if_req, if_addr=0x100; RAM[0x100..0x103]=13,00,00,93 → ram_a 0x100..0x103 in cycles 1–4, if_ready in cycle 6, if_inst=0x93000013, stall_req low in cycle 7.
- Contention: if_req and mem_req (load byte, addr 0x20, RAM=0xF5) in the same cycle → mem_ready in cycle 3 with mem_rdata=0x000000F5; IF granted afterwards, if_ready 7 cycles after mem_ready.
- Store half: mem_we=1, len=01, addr 0x1FFFF, wdata=0xAABBCCDD → writes DD@0x1FFFF, CC@0x00000 (wrap), ram_wr high exactly 2 cycles, mem_ready in cycle 3.
- Cancel: if_cancel asserted in cycle 3 of an IF read → FSM in IDLE next cycle, no if_ready pulse; a pending mem_req is granted at the following edge.
- Async reset asserted in cycle 2 of a word store → ram_wr and all outputs drop to 0 immediately, no further RAM writes; after release, a new request completes normally.
- len=11 load → behaves as a word read, ready in cycle 6.
